pwm_tone_generator: RTL and testbench

//  Note-to-tone audio back end: maps a 4-bit note code to a half-period interval (decoder stage),

---
 rtl/pwm_tone_generator.sv | 106 ++++++++++
 tb/tb_pwm_tone_generator.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_tone_generator.sv
// Purpose : note code -> half-period lookup, then a 50%-duty square wave on one pin (12 MHz clock).
// Latency : pwm_interval follows note one cycle later; a new interval restarts the counter on the next cycle.
// Backpres: none; free-running sink. Optional macro PWM_OCTAVE_EN adds the octave-up shift port.
module pwm_tone_generator #(
    parameter int NOTE_W     = 4,
    parameter int INTERVAL_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NOTE_W-1:0]     note,
`ifdef PWM_OCTAVE_EN
    input  logic [1:0]            octave,
`endif
    output logic [INTERVAL_W-1:0] pwm_interval,
    output logic                  pwm_out,
    output logic                  toggle
);

    logic [INTERVAL_W-1:0] base_interval;
    logic [INTERVAL_W-1:0] interval_d, interval_q;
    logic [INTERVAL_W-1:0] interval_prev_q;
    logic [INTERVAL_W-1:0] cnt_d, cnt_q;
    logic                  out_d, out_q;
    logic                  tog_d, tog_q;

    // Note lookup: round(12e6 / (2*f)) with A4 (note 10) at 440 Hz; note 0 is a rest.
    always_comb begin
        base_interval = '0;
        case (note)
            4'd1:    base_interval = INTERVAL_W'(22933);
            4'd2:    base_interval = INTERVAL_W'(21646);
            4'd3:    base_interval = INTERVAL_W'(20431);
            4'd4:    base_interval = INTERVAL_W'(19285);
            4'd5:    base_interval = INTERVAL_W'(18202);
            4'd6:    base_interval = INTERVAL_W'(17181);
            4'd7:    base_interval = INTERVAL_W'(16216);
            4'd8:    base_interval = INTERVAL_W'(15306);
            4'd9:    base_interval = INTERVAL_W'(14447);
            4'd10:   base_interval = INTERVAL_W'(13636);
            4'd11:   base_interval = INTERVAL_W'(12871);
            4'd12:   base_interval = INTERVAL_W'(12149);
            4'd13:   base_interval = INTERVAL_W'(11467);
            4'd14:   base_interval = INTERVAL_W'(10823);
            4'd15:   base_interval = INTERVAL_W'(10216);
            default: base_interval = '0;
        endcase
    end

    // Octave-up halves the interval per step; without the option the table value passes through.
    always_comb begin
`ifdef PWM_OCTAVE_EN
        interval_d = base_interval >> octave;
`else
        interval_d = base_interval;
`endif
    end

    // Decoder register plus the generator's private copy of last cycle's interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            interval_q      <= '0;
            interval_prev_q <= '0;
        end else begin
            interval_q      <= interval_d;
            interval_prev_q <= interval_q;
        end
    end

    // Generator next state: silence on zero, restart on interval change, else count to I-1 and flip.
    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        tog_d = 1'b0;
        if (interval_q == '0) begin
            cnt_d = '0;
            out_d = 1'b0;
        end else if (interval_q != interval_prev_q) begin
            // A new pitch starts a fresh half-period but keeps the current level, so no glitch edge.
            cnt_d = '0;
        end else if (cnt_q == (interval_q - INTERVAL_W'(1))) begin
            cnt_d = '0;
            out_d = ~out_q;
            tog_d = 1'b1;
        end else begin
            cnt_d = cnt_q + INTERVAL_W'(1);
        end
    end

    // Generator state registers; pwm_out and toggle come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            out_q <= 1'b0;
            tog_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
            tog_q <= tog_d;
        end
    end

    assign pwm_interval = interval_q;
    assign pwm_out      = out_q;
    assign toggle       = tog_q;

endmodule

// File: tb/tb_pwm_tone_generator.sv
module tb_pwm_tone_generator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  note = 4'd10;
`ifdef PWM_OCTAVE_EN
    logic [1:0]  octave = 2'd0;
`endif
    logic [15:0] pwm_interval;
    logic        pwm_out;
    logic        toggle;

    int tests = 0;
    int fails = 0;

    int exp_tab [16] = '{0, 22933, 21646, 20431, 19285, 18202, 17181, 16216,
                         15306, 14447, 13636, 12871, 12149, 11467, 10823, 10216};

    always #5 clk = ~clk;

    pwm_tone_generator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .note         (note),
`ifdef PWM_OCTAVE_EN
        .octave       (octave),
`endif
        .pwm_interval (pwm_interval),
        .pwm_out      (pwm_out),
        .toggle       (toggle)
    );

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count cycles until toggle is seen high; bounded by max_cycles.
    task automatic wait_toggle(input int max_cycles, output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        while (n < max_cycles && !seen) begin
            tick();
            n++;
            if (toggle === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        note  = 4'd10;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (pwm_interval !== 16'd0) begin
                fails++;
                $display("FAIL reset_interval: got %0d expected 0", pwm_interval);
            end
            tests++;
            if (pwm_out !== 1'b0) begin
                fails++;
                $display("FAIL reset_pwm_out: got %b expected 0", pwm_out);
            end
            tests++;
            if (toggle !== 1'b0) begin
                fails++;
                $display("FAIL reset_toggle: got %b expected 0", toggle);
            end
        end
    endtask

    // Walk every note code; the interval changes each cycle so the generator never toggles.
    task automatic test_decoder();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            note = 4'(i);
            tick();
            tests++;
            if (int'(pwm_interval) !== exp_tab[i]) begin
                fails++;
                $display("FAIL decode_note%0d: got %0d expected %0d", i, pwm_interval, exp_tab[i]);
            end
        end
    endtask

    // A4: first edge is one restart cycle plus a full half-period after the interval registers.
    task automatic test_tone();
        int n;
        bit seen;
        note = 4'd10;
        tick();
        tests++;
        if (pwm_interval !== 16'd13636) begin
            fails++;
            $display("FAIL tone_interval: got %0d expected 13636", pwm_interval);
        end
        wait_toggle(20000, n, seen);
        tests++;
        if (n !== 13637 || pwm_out !== 1'b1) begin
            fails++;
            $display("FAIL tone_first_edge: got %0d cycles out=%b expected 13637 out=1", n, pwm_out);
        end
        tick();
        tests++;
        if (toggle !== 1'b0) begin
            fails++;
            $display("FAIL tone_toggle_width: got %b expected 0", toggle);
        end
        wait_toggle(20000, n, seen);
        tests++;
        if (n + 1 !== 13636 || pwm_out !== 1'b0) begin
            fails++;
            $display("FAIL tone_high_phase: got %0d cycles out=%b expected 13636 out=0", n + 1, pwm_out);
        end
        wait_toggle(20000, n, seen);
        tests++;
        if (n !== 13636 || pwm_out !== 1'b1) begin
            fails++;
            $display("FAIL tone_low_phase: got %0d cycles out=%b expected 13636 out=1", n, pwm_out);
        end
    endtask

    // Rest while the output is high: interval clears, then the output is forced low and stays quiet.
    task automatic test_rest();
        bit bad;
        note = 4'd0;
        tick();
        tests++;
        if (pwm_interval !== 16'd0) begin
            fails++;
            $display("FAIL rest_interval: got %0d expected 0", pwm_interval);
        end
        tick();
        tests++;
        if (pwm_out !== 1'b0) begin
            fails++;
            $display("FAIL rest_pwm_out: got %b expected 0", pwm_out);
        end
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (toggle !== 1'b0 || pwm_out !== 1'b0) bad = 1'b1;
        end
        tests++;
        if (bad !== 1'b0) begin
            fails++;
            $display("FAIL rest_quiet: got activity=%b expected 0", bad);
        end
    endtask

    // Lowest note, then jump to the highest mid-period: level holds, count restarts from zero.
    task automatic test_switch();
        int n;
        bit seen;
        bit bad;
        note = 4'd1;
        tick();
        tests++;
        if (pwm_interval !== 16'd22933) begin
            fails++;
            $display("FAIL switch_low_interval: got %0d expected 22933", pwm_interval);
        end
        bad = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (toggle !== 1'b0) bad = 1'b1;
        end
        tests++;
        if (bad !== 1'b0) begin
            fails++;
            $display("FAIL switch_early_toggle: got toggle=%b expected 0", bad);
        end
        note = 4'd15;
        tick();
        tests++;
        if (pwm_interval !== 16'd10216 || pwm_out !== 1'b0) begin
            fails++;
            $display("FAIL switch_high_interval: got %0d out=%b expected 10216 out=0", pwm_interval, pwm_out);
        end
        // One restart cycle, then 10216 counted cycles to the edge.
        wait_toggle(20000, n, seen);
        tests++;
        if (n !== 10217 || pwm_out !== 1'b1) begin
            fails++;
            $display("FAIL switch_restart_edge: got %0d cycles out=%b expected 10217 out=1", n, pwm_out);
        end
    endtask

    // Output is high from the previous task; pull reset between clock edges.
    task automatic test_async_reset();
        int n;
        bit seen;
        for (int i = 0; i < 50; i++) tick();
        tests++;
        if (pwm_out !== 1'b1) begin
            fails++;
            $display("FAIL areset_pre_high: got %b expected 1", pwm_out);
        end
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if (pwm_out !== 1'b0 || pwm_interval !== 16'd0 || toggle !== 1'b0) begin
            fails++;
            $display("FAIL areset_immediate: got out=%b int=%0d tog=%b expected 0 0 0", pwm_out, pwm_interval, toggle);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tests++;
        if (pwm_interval !== 16'd10216 || pwm_out !== 1'b0) begin
            fails++;
            $display("FAIL areset_resume_interval: got %0d out=%b expected 10216 out=0", pwm_interval, pwm_out);
        end
        wait_toggle(20000, n, seen);
        tests++;
        if (n !== 10217 || pwm_out !== 1'b1) begin
            fails++;
            $display("FAIL areset_resume_edge: got %0d cycles out=%b expected 10217 out=1", n, pwm_out);
        end
    endtask

`ifdef PWM_OCTAVE_EN
    task automatic test_octave();
        int n;
        bit seen;
        note   = 4'd15;
        octave = 2'd3;
        tick();
        tests++;
        if (pwm_interval !== 16'd1277) begin
            fails++;
            $display("FAIL octave3_note15: got %0d expected 1277", pwm_interval);
        end
        note   = 4'd10;
        octave = 2'd2;
        tick();
        tests++;
        if (pwm_interval !== 16'd3409) begin
            fails++;
            $display("FAIL octave2_note10: got %0d expected 3409", pwm_interval);
        end
        wait_toggle(10000, n, seen);
        tests++;
        if (n !== 3410) begin
            fails++;
            $display("FAIL octave_first_edge: got %0d expected 3410", n);
        end
        wait_toggle(10000, n, seen);
        tests++;
        if (n !== 3409) begin
            fails++;
            $display("FAIL octave_half_period: got %0d expected 3409", n);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_decoder();
        test_tone();
        test_rest();
        test_switch();
        test_async_reset();
`ifdef PWM_OCTAVE_EN
        test_octave();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
